// File: rtl/coeff_accumulator_pkg.sv
// Shared command/state encodings and default modulus for the coefficient accumulator.
// The FSM state encoding doubles as the status output, so both use one code space.
package coeff_accumulator_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_IDLE  = 3'd0;
    localparam cmd_t CMD_WRITE = 3'd1;
    localparam cmd_t CMD_ACC   = 3'd2;
    localparam cmd_t CMD_READ  = 3'd3;
    localparam cmd_t CMD_CLEAR = 3'd4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_ACC   = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    localparam int Q_DEFAULT = 3329;

    // Reserved codes 5-7 behave as IDLE.
    function automatic cmd_t cmd_decode(input cmd_t c);
        return (c > CMD_CLEAR) ? CMD_IDLE : c;
    endfunction

endpackage

// File: rtl/coeff_accumulator_if.sv
// Command, input-beat and read-beat signals of the coefficient accumulator.
// master drives commands and beats; slave is the accumulator.
interface coeff_accumulator_if #(
    parameter int DW    = 16,
    parameter int AW    = 7,
    parameter int LANES = 2
) ();
    import coeff_accumulator_pkg::*;

    cmd_t                   cmd;
    logic                   in_valid;
    logic                   in_ready;
    logic [AW-1:0]          in_addr;
    logic [LANES*DW-1:0]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AW-1:0]          out_addr;
    logic [LANES*DW-1:0]    out_data;
    logic                   busy;
    cmd_t                   status;
    logic                   done;

    modport master (
        output cmd, in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data, busy, status, done
    );

    modport slave (
        input  cmd, in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data, busy, status, done
    );

endinterface

// File: rtl/coeff_mod_add.sv
// Combinational modular adder: (a + b) mod Q for operands already reduced below Q.
module coeff_mod_add import coeff_accumulator_pkg::*; #(
    parameter int DW = 16,
    parameter int Q  = Q_DEFAULT
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_sum
);
    localparam logic [DW:0] QW = (DW+1)'(Q);

    logic [DW:0] w_sum;

    // One extra bit holds the carry; a single conditional subtract suffices since a, b < Q.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = (w_sum >= QW) ? DW'(w_sum - QW) : w_sum[DW-1:0];

endmodule

// File: rtl/coeff_accumulator.sv
// Multi-lane coefficient store with write, modular accumulate, read sweep and clear sweep.
// ACC is a 2-stage read-modify-write pipeline with forwarding of the write made at the read edge.
module coeff_accumulator import coeff_accumulator_pkg::*; #(
    parameter int DW    = 16,
    parameter int AW    = 7,
    parameter int LANES = 2,
    parameter int Q     = Q_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    coeff_accumulator_if.slave   bus
);
    localparam int            DEPTH     = 2**AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

    logic [2:0]          r_state, w_state_next;
    cmd_t                w_cmd;
    logic                w_cmd_hold, w_in_ready, w_accept, w_pipe_empty, w_done;
    logic                r_v1, r_v2;
    logic [AW-1:0]       r_addr1, r_addr2;
    logic [LANES*DW-1:0] r_data1, r_data2;
    logic [AW:0]         r_sweep;
    logic                r_rd_v, r_out_valid;
    logic [AW-1:0]       r_rd_addr, r_out_addr;
    logic [LANES*DW-1:0] r_out_data;
    logic                w_out_free, w_rd_free, w_issue;
    logic                w_we, w_re;
    logic [AW-1:0]       w_waddr, w_raddr;
    logic [LANES*DW-1:0] w_wdata, w_rdata, w_sum;
    logic                r_wr_v;
    logic [AW-1:0]       r_wr_addr;
    logic [LANES*DW-1:0] r_wr_data;

    assign w_cmd        = cmd_decode(bus.cmd);
    assign w_cmd_hold   = (w_cmd == r_state);
    assign w_in_ready   = ((r_state == ST_WRITE) || (r_state == ST_ACC)) && w_cmd_hold;
    assign w_accept     = w_in_ready && bus.in_valid;
    assign w_pipe_empty = !r_v1 && !r_v2;
    assign w_out_free   = !r_out_valid || bus.out_ready;
    assign w_rd_free    = !r_rd_v || w_out_free;
    assign w_issue      = (r_state == ST_READ) && w_cmd_hold && !r_sweep[AW] && w_rd_free;

    always_comb begin
        w_done = 1'b0;
        if (w_cmd_hold) begin
            if (r_state == ST_READ)
                w_done = r_out_valid && bus.out_ready && (r_out_addr == LAST_ADDR);
            else if (r_state == ST_CLEAR)
                w_done = (r_sweep[AW-1:0] == LAST_ADDR);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:            w_state_next = w_cmd;
            ST_WRITE, ST_ACC:   if (!w_cmd_hold && w_pipe_empty) w_state_next = ST_IDLE;
            ST_READ, ST_CLEAR:  if (!w_cmd_hold || w_done) w_state_next = ST_IDLE;
            default:            w_state_next = ST_IDLE;
        endcase
    end

    // Modes never overlap, so one write port and one read port per lane are shared.
    always_comb begin
        w_we    = r_v2;
        w_waddr = r_addr2;
        w_wdata = w_sum;
        w_raddr = r_addr1;
        w_re    = 1'b1;
        if (r_state == ST_WRITE) begin
            w_we    = w_accept;
            w_waddr = bus.in_addr;
            w_wdata = bus.in_data;
        end else if (r_state == ST_CLEAR) begin
            w_we    = w_cmd_hold;
            w_waddr = r_sweep[AW-1:0];
            w_wdata = '0;
        end
        if (r_state == ST_READ) begin
            w_raddr = r_sweep[AW-1:0];
            w_re    = w_rd_free;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] r_mem [DEPTH];
            logic [DW-1:0] r_rdata;
            logic [DW-1:0] w_a;

            always_ff @(posedge clk) begin
                if (w_we) r_mem[w_waddr] <= w_wdata[gi*DW +: DW];
                if (w_re) r_rdata <= r_mem[w_raddr];
            end

            assign w_rdata[gi*DW +: DW] = r_rdata;
            // A write landing on the same edge as our read is not seen by the RAM; take it here.
            assign w_a = (r_wr_v && (r_wr_addr == r_addr2)) ? r_wr_data[gi*DW +: DW] : r_rdata;

            coeff_mod_add #(.DW(DW), .Q(Q)) u_add (
                .i_a   (w_a),
                .i_b   (r_data2[gi*DW +: DW]),
                .o_sum (w_sum[gi*DW +: DW])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_sweep     <= '0;
            r_rd_v      <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_wr_v      <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_v1      <= w_accept && (r_state == ST_ACC);
            r_addr1   <= bus.in_addr;
            r_data1   <= bus.in_data;
            r_v2      <= r_v1;
            r_addr2   <= r_addr1;
            r_data2   <= r_data1;
            r_wr_v    <= w_we;
            r_wr_addr <= w_waddr;
            r_wr_data <= w_wdata;

            if (w_state_next != r_state)
                r_sweep <= '0;
            else if (w_issue || (r_state == ST_CLEAR))
                r_sweep <= r_sweep + 1'b1;

            // Two-register read path (RAM output, output beat) so a stall holds both in place.
            if (w_state_next != ST_READ) begin
                r_rd_v      <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_rd_free) begin
                    r_rd_v    <= w_issue;
                    r_rd_addr <= r_sweep[AW-1:0];
                end
                if (w_out_free) begin
                    r_out_valid <= r_rd_v;
                    if (r_rd_v) begin
                        r_out_addr <= r_rd_addr;
                        r_out_data <= w_rdata;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = !w_pipe_empty || (r_state == ST_READ) || (r_state == ST_CLEAR);
    assign bus.status    = r_state;
    assign bus.done      = w_done;

endmodule
